// File: rtl/dp_job_scheduler.sv
// Round-robin front end for the iterative datapath: grants one requester, clears and
// starts the datapath controller, waits for its sticky done and acks or times out.
module dp_job_scheduler #(
    parameter int N_REQ      = 4,
    parameter int CLR_CYCLES = 1,
    parameter int TIMEOUT    = 255
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_REQ-1:0]         req,
    output logic [N_REQ-1:0]         gnt,
    output logic [$clog2(N_REQ)-1:0] sel,
    output logic                     load,
    output logic                     dp_rst,
    output logic                     dp_start,
    input  logic                     dp_done,
    output logic [N_REQ-1:0]         ack,
    output logic                     err,
    output logic                     busy,
    output logic [7:0]               job_cnt
);

    localparam int SW = $clog2(N_REQ);

    typedef enum logic [2:0] {
        IDLE,
        GRANT,
        CLEAR,
        START,
        WAIT,
        ACK
    } state_t;

    state_t          state;
    logic [SW-1:0]   ptr;
    logic [SW-1:0]   sel_r;
    logic [SW-1:0]   winner;
    logic [3:0]      clr_cnt;
    logic [7:0]      wcnt;
    logic            err_flag;
    logic [N_REQ-1:0] sel_onehot;

    // Scan downward so the set request closest to ptr (in wrap order) is the last writer.
    always_comb begin
        int idx;
        idx    = 0;
        winner = ptr;
        for (int i = N_REQ - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % N_REQ;
            if (req[idx]) begin
                winner = SW'(idx);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            ptr      <= '0;
            sel_r    <= '0;
            clr_cnt  <= '0;
            wcnt     <= '0;
            err_flag <= 1'b0;
            job_cnt  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (|req) begin
                        sel_r <= winner;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    clr_cnt <= 4'(CLR_CYCLES - 1);
                    state   <= CLEAR;
                end
                CLEAR: begin
                    if (clr_cnt == 4'd0) begin
                        state <= START;
                    end else begin
                        clr_cnt <= clr_cnt - 4'd1;
                    end
                end
                START: begin
                    wcnt  <= '0;
                    state <= WAIT;
                end
                // Done takes priority over the timeout when both land on the same cycle.
                WAIT: begin
                    wcnt <= wcnt + 8'd1;
                    if (dp_done) begin
                        err_flag <= 1'b0;
                        state    <= ACK;
                    end else if (wcnt == 8'(TIMEOUT - 1)) begin
                        err_flag <= 1'b1;
                        state    <= ACK;
                    end
                end
                ACK: begin
                    job_cnt <= job_cnt + 8'd1;
                    if (int'(sel_r) == N_REQ - 1) begin
                        ptr <= '0;
                    end else begin
                        ptr <= sel_r + SW'(1);
                    end
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sel_onehot = {{(N_REQ-1){1'b0}}, 1'b1} << sel_r;

    assign busy     = (state != IDLE);
    assign gnt      = busy ? sel_onehot : '0;
    assign sel      = busy ? sel_r : '0;
    assign load     = (state == GRANT);
    assign dp_start = (state == START);
    assign ack      = (state == ACK) ? sel_onehot : '0;
    assign err      = (state == ACK) && err_flag;
    // The datapath stays cleared while the scheduler itself is in reset.
    assign dp_rst   = ~rst | (state == CLEAR);

endmodule

// File: tb/tb_dp_job_scheduler.sv
// Self-checking bench for dp_job_scheduler: directed vectors on two parameter sets plus
// randomized traffic compared against a cycle-offset job model.
module tb_dp_job_scheduler;

    localparam int N     = 4;
    localparam int CLR_A = 1;
    localparam int TO_A  = 255;
    localparam int CLR_B = 3;
    localparam int TO_B  = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;

    logic [3:0] req_a = '0, gnt_a, ack_a;
    logic [1:0] sel_a;
    logic       load_a, dprst_a, start_a, err_a, busy_a;
    logic       done_a = 1'b0;
    logic [7:0] cnt_a;

    logic [3:0] req_b = '0, gnt_b, ack_b;
    logic [1:0] sel_b;
    logic       load_b, dprst_b, start_b, err_b, busy_b;
    logic       done_b = 1'b0;
    logic [7:0] cnt_b;

    int checks = 0;
    int errors = 0;

    dp_job_scheduler #(.N_REQ(N), .CLR_CYCLES(CLR_A), .TIMEOUT(TO_A)) dut_a (
        .clk(clk), .rst(rst), .req(req_a), .gnt(gnt_a), .sel(sel_a), .load(load_a),
        .dp_rst(dprst_a), .dp_start(start_a), .dp_done(done_a), .ack(ack_a),
        .err(err_a), .busy(busy_a), .job_cnt(cnt_a)
    );

    dp_job_scheduler #(.N_REQ(N), .CLR_CYCLES(CLR_B), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst(rst), .req(req_b), .gnt(gnt_b), .sel(sel_b), .load(load_b),
        .dp_rst(dprst_b), .dp_start(start_b), .dp_done(done_b), .ack(ack_b),
        .err(err_b), .busy(busy_b), .job_cnt(cnt_b)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] req;
        int         done_delay;
        logic [3:0] exp_gnt;
        logic       exp_err;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[13];

    localparam logic [22:0] RESET_A = {4'b0, 2'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 8'h00};
    localparam logic [20:0] RESET_B = {4'b0, 1'b0, 1'b1, 1'b0, 4'b0, 1'b0, 1'b0, 8'h00};

    // Behavioural model: a job is tracked by its cycle offset from the grant decision.
    bit         m_busy;
    int         m_t, m_sel, m_ptr, m_ack_t;
    bit         m_err;
    logic [7:0] m_cnt;

    function automatic logic [22:0] pack_a();
        return {gnt_a, sel_a, load_a, dprst_a, start_a, ack_a, err_a, busy_a, cnt_a};
    endfunction

    function automatic logic [20:0] pack_b();
        return {gnt_b, load_b, dprst_b, start_b, ack_b, err_b, busy_b, cnt_b};
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 20)
                $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic doReset();
        @(negedge clk);
        rst    = 1'b0;
        req_a  = '0;
        done_a = 1'b0;
        req_b  = '0;
        done_b = 1'b0;
        #1;
        checkOutput("reset_a", 32'(pack_a()), 32'(RESET_A));
        checkOutput("reset_b", 32'(pack_b()), 32'(RESET_B));
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        checkOutput("dp_rst_release", 32'(dprst_a), 32'd0);
    endtask

    task automatic applyStimulus(input vec_t v);
        int n;
        req_a  = v.req;
        done_a = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt_a == '0 && n < 20);
        checkOutput("grant", 32'(gnt_a), 32'(v.exp_gnt));
        checkOutput("load", 32'(load_a), 32'd1);
        n = 0;
        while (!start_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        checkOutput("start_seen", 32'(start_a), 32'd1);
        repeat (v.done_delay) @(negedge clk);
        done_a = 1'b1;
        @(negedge clk);
        checkOutput("ack", 32'(ack_a), 32'(v.exp_gnt));
        checkOutput("err", 32'(err_a), 32'(v.exp_err));
        done_a = 1'b0;
        @(negedge clk);
        checkOutput("job_cnt", 32'(cnt_a), 32'(v.exp_cnt));
        checkOutput("idle", 32'(busy_a), 32'd0);
    endtask

    // done_off: -1 never, 0 high from the start, otherwise raised after checking that offset.
    task automatic runB(input string name, input logic [3:0] r, input int done_off,
                        input logic [3:0] exp_gnt, input int ack_off, input logic exp_err,
                        input logic [7:0] exp_cnt);
        logic [20:0] exp;
        req_b  = r;
        done_b = (done_off == 0);
        for (int o = 1; o <= ack_off + 1; o++) begin
            @(negedge clk);
            exp = {(o <= ack_off) ? exp_gnt : 4'b0, o == 1, (o >= 2 && o <= 1 + CLR_B),
                   o == 2 + CLR_B, (o == ack_off) ? exp_gnt : 4'b0, (o == ack_off) && exp_err,
                   o <= ack_off, (o == ack_off + 1) ? exp_cnt : exp_cnt - 8'd1};
            checkOutput(name, 32'(pack_b()), 32'(exp));
            if (o == 1) req_b = '0;
            if (done_off > 0 && o == done_off) done_b = 1'b1;
        end
        done_b = 1'b0;
    endtask

    function automatic logic [22:0] model_out();
        logic [3:0] oh;
        logic       ack_now;
        oh      = m_busy ? 4'(1 << m_sel) : 4'b0;
        ack_now = m_busy && m_ack_t != 0 && m_t == m_ack_t;
        return {oh, m_busy ? 2'(m_sel) : 2'b0, m_busy && m_t == 1,
                m_busy && m_t >= 2 && m_t <= 1 + CLR_A, m_busy && m_t == 2 + CLR_A,
                ack_now ? oh : 4'b0, ack_now && m_err, m_busy, m_cnt};
    endfunction

    task automatic model_step(input logic [3:0] r, input logic d);
        int w;
        if (!m_busy) begin
            if (r != '0) begin
                w = -1;
                for (int k = 0; k < N; k++)
                    if (w < 0 && r[(m_ptr + k) % N]) w = (m_ptr + k) % N;
                m_sel   = w;
                m_busy  = 1;
                m_t     = 1;
                m_ack_t = 0;
            end
        end else if (m_ack_t != 0 && m_t == m_ack_t) begin
            m_busy = 0;
            m_ptr  = (m_sel + 1) % N;
            m_cnt  = m_cnt + 8'd1;
        end else begin
            if (m_ack_t == 0 && m_t >= 3 + CLR_A) begin
                if (d) begin
                    m_ack_t = m_t + 1;
                    m_err   = 0;
                end else if (m_t - (3 + CLR_A) == TO_A - 1) begin
                    m_ack_t = m_t + 1;
                    m_err   = 1;
                end
            end
            m_t++;
        end
    endtask

    initial begin
        int n;
        vecs[0]  = '{4'b1111, 1, 4'b0001, 1'b0, 8'd1};
        vecs[1]  = '{4'b1111, 1, 4'b0010, 1'b0, 8'd2};
        vecs[2]  = '{4'b1111, 1, 4'b0100, 1'b0, 8'd3};
        vecs[3]  = '{4'b1111, 1, 4'b1000, 1'b0, 8'd4};
        vecs[4]  = '{4'b1111, 1, 4'b0001, 1'b0, 8'd5};
        vecs[5]  = '{4'b1111, 1, 4'b0010, 1'b0, 8'd6};
        vecs[6]  = '{4'b1111, 1, 4'b0100, 1'b0, 8'd7};
        vecs[7]  = '{4'b1111, 1, 4'b1000, 1'b0, 8'd8};
        vecs[8]  = '{4'b1010, 2, 4'b0010, 1'b0, 8'd9};
        vecs[9]  = '{4'b0011, 1, 4'b0001, 1'b0, 8'd10};
        vecs[10] = '{4'b1001, 3, 4'b1000, 1'b0, 8'd11};
        vecs[11] = '{4'b0100, 5, 4'b0100, 1'b0, 8'd12};
        vecs[12] = '{4'b0110, 1, 4'b0010, 1'b0, 8'd13};

        // Single job, done three cycles after start.
        doReset();
        req_a = 4'b0001;
        @(negedge clk);
        checkOutput("first_grant", 32'({gnt_a, load_a, dprst_a, sel_a, busy_a}), 32'({4'b0001, 1'b1, 1'b0, 2'b00, 1'b1}));
        req_a = '0;
        @(negedge clk);
        checkOutput("first_clear", 32'({gnt_a, load_a, dprst_a, start_a}), 32'({4'b0001, 1'b0, 1'b1, 1'b0}));
        @(negedge clk);
        checkOutput("first_start", 32'({dprst_a, start_a}), 32'({1'b0, 1'b1}));
        @(negedge clk);
        checkOutput("first_wait", 32'({start_a, busy_a, ack_a}), 32'({1'b0, 1'b1, 4'b0}));
        repeat (2) @(negedge clk);
        done_a = 1'b1;
        checkOutput("no_early_ack", 32'(ack_a), 32'd0);
        @(negedge clk);
        checkOutput("first_ack", 32'({ack_a, err_a}), 32'({4'b0001, 1'b0}));
        done_a = 1'b0;
        @(negedge clk);
        checkOutput("first_cnt", 32'({cnt_a, busy_a, ack_a}), 32'({8'd1, 1'b0, 4'b0}));

        doReset();
        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Timeout, stale done during a long clear, and done on the final allowed wait cycle.
        doReset();
        runB("timeout", 4'b0001, -1, 4'b0001, 10, 1'b1, 8'd1);
        runB("stuck_done", 4'b0010, 0, 4'b0010, 7, 1'b0, 8'd2);
        runB("last_wait_done", 4'b0100, 9, 4'b0100, 10, 1'b0, 8'd3);

        // Asynchronous reset in the middle of a wait aborts the job.
        req_a  = 4'b1111;
        done_a = 1'b0;
        n = 0;
        while (!start_a && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkOutput("abort_start_seen", 32'(start_a), 32'd1);
        repeat (2) @(negedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("async_reset", 32'(pack_a()), 32'(RESET_A));
        req_a = '0;
        repeat (3) begin
            @(negedge clk);
            checkOutput("no_ack_in_reset", 32'({ack_a, dprst_a}), 32'({4'b0, 1'b1}));
        end
        req_a = 4'b0100;
        rst   = 1'b1;
        @(negedge clk);
        checkOutput("grant_after_reset", 32'({gnt_a, sel_a}), 32'({4'b0100, 2'd2}));

        // Randomized traffic against the model.
        doReset();
        m_busy = 0; m_t = 0; m_sel = 0; m_ptr = 0; m_ack_t = 0; m_err = 0; m_cnt = '0;
        for (int i = 0; i < 4000; i++) begin
            checkOutput("random", 32'(pack_a()), 32'(model_out()));
            req_a  = ($urandom_range(0, 3) == 0) ? 4'b0 : 4'($urandom_range(0, 15));
            done_a = ($urandom_range(0, 3) == 0);
            @(posedge clk);
            model_step(req_a, done_a);
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/dp_job_scheduler.md
# dp_job_scheduler

Front-end scheduler for the four-flag iterative datapath and its controller. It arbitrates up to N_REQ requesters round-robin and steers the granted requester's operands into the datapath. It clears and starts the datapath controller, waits for its sticky done, returns a per-requester completion pulse, and flags jobs that exceed a watchdog limit. The datapath controller's done never self-clears, so this block issues a clear pulse on its reset before every job.

## Interface
- N_REQ, 4: number of requesters (2..8).
- CLR_CYCLES, 1: cycles dp_rst is held high before each job (1..15).
- TIMEOUT, 255: maximum WAIT cycles before the job is aborted with err (2..255).
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  N_REQ  job request per requester; level-sensitive, sampled only in IDLE.
- gnt  out  N_REQ  one-hot grant, held from GRANT through ACK.
- sel  out  clog2(N_REQ)  index of granted requester (operand mux select), held from GRANT through ACK.
- load  out  1  one-cycle pulse in GRANT; datapath captures operands selected by sel.
- dp_rst  out  1  active-high clear to datapath controller.
- dp_start  out  1  one-cycle start pulse to datapath controller.
- dp_done  in  1  done from datapath controller (sticky until cleared).
- ack  out  N_REQ  one-cycle completion pulse to the granted requester.
- err  out  1  one-cycle pulse coincident with ack when the job timed out.
- busy  out  1  high in every state except IDLE.
- job_cnt  out  8  count of completed jobs, including timed-out jobs; wraps 255->0.

## Operation
- States: IDLE, GRANT, CLEAR, START, WAIT, ACK. All outputs are decoded from registered state, counters and pointer. Nothing is combinational from inputs, except dp_rst, which also follows rst.
- IDLE: if req != 0, pick a winner and go to GRANT. Otherwise stay.
- Arbitration is round-robin. Search starts at index ptr and wraps modulo N_REQ; the first set req bit wins. ptr resets to 0. In ACK, ptr <= (sel+1) mod N_REQ.
- GRANT: gnt[sel]=1, load=1. Go to CLEAR and load the clear counter with CLR_CYCLES-1.
- CLEAR: dp_rst=1. Count down and go to START when the counter reaches 0, giving exactly CLR_CYCLES cycles.
- START: dp_start=1 for one cycle. Go to WAIT and clear wcnt (8 bits).
- WAIT: wcnt increments each cycle.
  - If dp_done=1, go to ACK with err_flag=0.
  - Else if wcnt==TIMEOUT-1, go to ACK with err_flag=1.
  - This allows at most TIMEOUT WAIT cycles. If done and the timeout condition occur in the same cycle, done wins (err_flag=0).
- ACK: ack[sel]=1 and err=err_flag. job_cnt increments, ptr updates, and the next state is IDLE. gnt and sel drop when IDLE is entered.
- dp_done is ignored outside WAIT. A stale done left from a previous job is removed by CLEAR.
- req changes after grant are ignored; the job always runs to ACK. A requester that keeps req high re-enters arbitration in IDLE.
- dp_rst = ~rst | (state==CLEAR), so the datapath is also held clear during scheduler reset.

## Timing
- Reset (rst=0) forces the following immediately:
  - state=IDLE; ptr=0; job_cnt=0; wcnt=0; err_flag=0.
  - gnt=0, sel=0, load=0, dp_start=0, ack=0, err=0, busy=0.
  - dp_rst=1.
  - Reset mid-job aborts with no ack.
- Winner chosen in IDLE at cycle t gives this sequence (CLR_CYCLES=1):
  - GRANT at t+1, CLEAR at t+2, START at t+3, first WAIT at t+4.
  - If dp_done is seen at t+4, ACK is at t+5 and IDLE at t+6.
  - Minimum job period is 6 cycles.
- Worst case: ACK arrives TIMEOUT+CLR_CYCLES+3 cycles after the IDLE decision.
- Back-to-back jobs: after ACK at cycle a, the next grant appears at a+2.

## Test plan
- Reset, then req=0001 with dp_done asserted 3 cycles after dp_start:
  - gnt=0001 and load=1 for one cycle, then dp_rst=1 for 1 cycle, then dp_start for 1 cycle.
  - ack=0001 arrives 1 cycle after done, with err=0 and job_cnt=1.
- req=1111 held for 8 jobs, each finishing with immediate done: grants go 0001,0010,0100,1000,0001,... and ack always matches the grant.
- TIMEOUT=4 with dp_done never asserted: exactly 4 WAIT cycles, then ack plus err=1, and job_cnt increments.
- dp_done rises on the last allowed WAIT cycle (wcnt==TIMEOUT-1): ack with err=0.
- dp_done stuck high from a prior job with CLR_CYCLES=3: dp_rst is high for 3 cycles, and done is not accepted before the WAIT state.
- rst driven low during WAIT: all outputs go to their reset values at once, dp_rst=1, and no ack. After release with req=0100, gnt=0100 is granted because ptr=0 search starts at index 0.
